cpu_test_monitor: RTL and testbench

Synthesizable self-checking monitor for the rv32i core test environment. It snoops the data-memory store bus and the retire strobe, then captures a signature region into an internal buffer. It detects a tohost-style end-of-test write and flags pass, fail or timeout, with cycle and retired-instruction counts. It replaces fixed-delay "run N cycles then dump registers" checking with a parametrised, deterministic end-of-test handshake that benches and FPGA builds share.

---
 rtl/cpu_test_monitor_pkg.sv | 22 ++
 rtl/cpu_test_monitor_sig_buffer.sv | 45 ++++
 rtl/cpu_test_monitor.sv | 153 +++++++++++++++
 tb/tb_cpu_test_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_test_monitor_pkg.sv
// cpu_test_monitor_pkg
// Shared constants for the rv32i end-of-test monitor: FSM state encoding,
// the mailbox value that means "pass", and the address-to-signature-word
// helper used by the top-level address decoder.
package cpu_test_monitor_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam int unsigned PASS_CODE = 1;

    // Word offset of a byte address relative to the signature base.
    // Only meaningful when addr >= base; the caller range-checks.
    function automatic logic [31:0] sig_word_offset(input logic [31:0] addr,
                                                    input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/cpu_test_monitor_sig_buffer.sv
// sig_buffer
// Signature storage: DEPTH words of DATA_WIDTH, one synchronous write port,
// one registered read port (1-cycle latency, read-before-write on a
// same-index collision) and a per-word written flag.
// Ports:
//   clk, rst          clock, async active-high reset
//   clr               clear all valid flags (monitor re-arm)
//   we/wr_idx/wr_data capture write
//   rd_idx/rd_data    registered readout
//   valid             bit i set once word i has been written
module sig_buffer #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DEPTH-1:0]      valid
);

    // Storage is deliberately not reset; consumers qualify it with valid.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      valid <= '0;
        else if (clr) valid <= '0;
        else if (we)  valid[wr_idx] <= 1'b1;
    end

endmodule

// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor
// Snoops the data-memory store bus and the retire strobe of the rv32i core.
// Captures stores into the signature window, watches the tohost mailbox for
// the end-of-test write and reports pass / fail / timeout together with
// cycle and retired-instruction counts.
// Ports:
//   clk, rst                      clock, async active-high reset
//   start                         clear and arm (wins over everything else)
//   mem_we, mem_addr, mem_wdata   full-word store bus
//   retire                        one instruction retired
//   busy, done, pass, timeout     registered status decoded from state
//   exit_code                     mailbox value >> 1 after a failing test
//   cycle_count, instret_count    saturating counters, active in RUN
//   sig_valid                     per-word written flags
//   sig_rd_idx, sig_rd_data       signature readout, 1-cycle latency
module cpu_test_monitor
    import cpu_test_monitor_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] SIG_BASE       = 'h0000_0400,
    parameter int                    SIG_DEPTH      = 8,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 'h0000_07FC,
    parameter int                    TIMEOUT_CYCLES = 200,
    parameter int                    CNT_WIDTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mem_we,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic                         retire,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [DATA_WIDTH-1:0]        exit_code,
    output logic [CNT_WIDTH-1:0]         cycle_count,
    output logic [CNT_WIDTH-1:0]         instret_count,
    output logic [SIG_DEPTH-1:0]         sig_valid,
    input  logic [$clog2(SIG_DEPTH)-1:0] sig_rd_idx,
    output logic [DATA_WIDTH-1:0]        sig_rd_data
);

    localparam int IDX_W = $clog2(SIG_DEPTH);

    logic [2:0] state, state_nxt;
    logic       run;

    logic [31:0]      addr32;
    logic [31:0]      sig_off;
    logic             sig_hit;
    logic             mbox_hit;
    logic             cap_we;
    logic             mbox_pass;
    logic             mbox_fail;
    logic             tmo_hit;
    logic [IDX_W-1:0] cap_idx;

    assign run = (state == ST_RUN);

    // ---------------- address decode ----------------
    assign addr32  = 32'(mem_addr);
    assign sig_off = sig_word_offset(addr32, 32'(SIG_BASE));
    assign cap_idx = sig_off[IDX_W-1:0];

    assign sig_hit = mem_we && (mem_addr[1:0] == 2'b00)
                  && (addr32 >= 32'(SIG_BASE))
                  && (sig_off < 32'(SIG_DEPTH));
    assign mbox_hit = mem_we && (mem_addr == TOHOST_ADDR);

    // start suppresses the capture so the re-armed buffer starts empty.
    assign cap_we    = run && sig_hit && !start;
    assign mbox_pass = run && mbox_hit && (mem_wdata == DATA_WIDTH'(PASS_CODE));
    assign mbox_fail = run && mbox_hit && mem_wdata[0]
                    && (mem_wdata != DATA_WIDTH'(PASS_CODE));

    // Compared at 32 bits so a narrow counter that saturates below the
    // limit simply never times out instead of aliasing.
    assign tmo_hit = run && (32'(cycle_count) == 32'(TIMEOUT_CYCLES - 1));

    // ---------------- FSM ----------------
    // Priority: start, then mailbox (pass/fail), then timeout.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else if (run) begin
            if (mbox_pass)      state_nxt = ST_PASS;
            else if (mbox_fail) state_nxt = ST_FAIL;
            else if (tmo_hit)   state_nxt = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt == ST_RUN);
            done    <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL);
            pass    <= (state_nxt == ST_PASS);
            timeout <= (state_nxt == ST_TIMEOUT);
        end
    end

    // ---------------- counters ----------------
    // Counting is gated on the current state, so the terminal transition
    // cycle still counts and the values freeze afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else if (start) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else if (run) begin
            if (cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;
            if (retire && (instret_count != '1))
                instret_count <= instret_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            exit_code <= '0;
        else if (start)     exit_code <= '0;
        else if (mbox_fail) exit_code <= mem_wdata >> 1;
    end

    // ---------------- signature storage ----------------
    sig_buffer #(
        .DEPTH      (SIG_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_sig_buffer (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .we      (cap_we),
        .wr_idx  (cap_idx),
        .wr_data (mem_wdata),
        .rd_idx  (sig_rd_idx),
        .rd_data (sig_rd_data),
        .valid   (sig_valid)
    );

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Directed bench for cpu_test_monitor. A second instance with a 4-bit
// counter width shares the same stimulus and is checked for saturation.
module tb_cpu_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        retire = 1'b0;
    logic [2:0]  sig_rd_idx = '0;

    logic        busy, done, pass, timeout;
    logic [31:0] exit_code;
    logic [15:0] cycle_count, instret_count;
    logic [7:0]  sig_valid;
    logic [31:0] sig_rd_data;

    logic        s_busy, s_done, s_pass, s_timeout;
    logic [31:0] s_exit_code;
    logic [3:0]  s_cycle_count, s_instret_count;
    logic [7:0]  s_sig_valid;
    logic [31:0] s_sig_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_test_monitor dut (
        .clk(clk), .rst(rst), .start(start), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .retire(retire),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .exit_code(exit_code), .cycle_count(cycle_count),
        .instret_count(instret_count), .sig_valid(sig_valid),
        .sig_rd_idx(sig_rd_idx), .sig_rd_data(sig_rd_data)
    );

    cpu_test_monitor #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .retire(retire),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout),
        .exit_code(s_exit_code), .cycle_count(s_cycle_count),
        .instret_count(s_instret_count), .sig_valid(s_sig_valid),
        .sig_rd_idx(sig_rd_idx), .sig_rd_data(s_sig_rd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        step();
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    initial begin
        // ---- reset state ----
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycle_count, 0);
        chk("rst_instret", instret_count, 0);
        chk("rst_sig_valid", sig_valid, 0);
        chk("rst_exit", exit_code, 0);
        chk("rst_rd_data", sig_rd_data, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // ---- arm, count, async reset mid-RUN ----
        do_start();
        chk("arm_busy", busy, 1);
        chk("arm_cycles0", cycle_count, 0);
        step();
        chk("arm_cycles1", cycle_count, 1);
        step();
        chk("arm_cycles2", cycle_count, 2);
        repeat (8) step();
        chk("arm_cycles10", cycle_count, 10);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cycles", cycle_count, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);

        // ---- pass flow ----
        do_start();
        retire = 1'b1;
        repeat (5) step();
        retire = 1'b0;
        store(32'h400, 32'd30);
        store(32'h404, 32'd23);
        store(32'h7FC, 32'd1);
        chk("pass_pass", pass, 1);
        chk("pass_done", done, 1);
        chk("pass_busy", busy, 0);
        chk("pass_instret", instret_count, 5);
        chk("pass_cycles", cycle_count, 8);
        chk("pass_sig_valid", sig_valid, 8'b0000_0011);
        sig_rd_idx = 3'd1;
        step();
        chk("pass_rd_data", sig_rd_data, 32'h17);
        chk("pass_cycles_frozen", cycle_count, 8);

        // ---- restart from PASS, then even and odd mailbox ----
        do_start();
        chk("restart_busy", busy, 1);
        chk("restart_pass", pass, 0);
        chk("restart_cycles", cycle_count, 0);
        chk("restart_instret", instret_count, 0);
        chk("restart_sig_valid", sig_valid, 0);
        store(32'h7FC, 32'd0);
        chk("even_mbox_busy", busy, 1);
        store(32'h7FC, 32'd7);
        chk("fail_done", done, 1);
        chk("fail_pass", pass, 0);
        chk("fail_busy", busy, 0);
        chk("fail_exit", exit_code, 3);
        store(32'h400, 32'd9);
        chk("fail_store_ignored", sig_valid, 0);

        // ---- address filtering and read-before-write ----
        do_start();
        chk("refail_exit_clr", exit_code, 0);
        store(32'h402, 32'd1);
        store(32'h420, 32'd2);
        store(32'h3FC, 32'd3);
        chk("filter_none", sig_valid, 0);
        store(32'h41C, 32'hDEAD);
        chk("filter_top_word", sig_valid, 8'h80);
        sig_rd_idx = 3'd7;
        step();
        chk("rd_word7", sig_rd_data, 32'hDEAD);
        store(32'h41C, 32'hBEEF);
        chk("rd_collision_old", sig_rd_data, 32'hDEAD);
        step();
        chk("rd_collision_new", sig_rd_data, 32'hBEEF);

        // ---- timeout boundary ----
        do_start();
        repeat (199) step();
        chk("tmo_pre_busy", busy, 1);
        chk("tmo_pre_flag", timeout, 0);
        chk("tmo_pre_cycles", cycle_count, 199);
        step();
        chk("tmo_flag", timeout, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_done", done, 0);
        chk("tmo_cycles", cycle_count, 200);
        store(32'h400, 32'd5);
        chk("tmo_store_ignored", sig_valid, 0);
        chk("tmo_cycles_frozen", cycle_count, 200);

        // ---- mailbox on the timeout cycle wins ----
        do_start();
        repeat (199) step();
        store(32'h7FC, 32'd1);
        chk("tmo_race_pass", pass, 1);
        chk("tmo_race_timeout", timeout, 0);
        chk("tmo_race_cycles", cycle_count, 200);

        // ---- saturation on the 4-bit instance ----
        do_start();
        retire = 1'b1;
        repeat (20) step();
        retire = 1'b0;
        chk("sat_instret", s_instret_count, 15);
        chk("sat_cycles", s_cycle_count, 15);
        chk("wide_instret", instret_count, 20);
        store(32'h404, 32'd4);
        store(32'h7FC, 32'd1);
        chk("sat_pass", s_pass, 1);
        chk("sat_sig_valid", s_sig_valid, 8'h02);
        do_start();
        chk("sat_restart_busy", s_busy, 1);
        chk("sat_restart_instret", s_instret_count, 0);
        chk("sat_restart_cycles", s_cycle_count, 0);
        chk("sat_restart_sig_valid", s_sig_valid, 0);
        chk("main_restart_busy", busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
